epcs_rx_link_ctrl: RTL and testbench



---
 rtl/epcs_pkg.sv | 13 +
 rtl/epcs_sync_cnt.sv | 20 ++
 rtl/epcs_rx_link_ctrl.sv | 143 ++++++++++++++
 tb/tb_epcs_rx_link_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/epcs_pkg.sv
// Shared EPCS receive-path definitions: word width, default sync pattern and
// the link-controller state encoding.
package epcs_pkg;
  localparam int EPCS_W = 20;
  localparam logic [EPCS_W-1:0] SYNC_WORD_DEF = 20'hCF9C3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;
endpackage

// File: rtl/epcs_sync_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module epcs_sync_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/epcs_rx_link_ctrl.sv
// EPCS RX link-alignment controller: hunts for the periodic sync word, requests
// SERDES bit-slips until framing is found, then forwards framed data with sof.
module epcs_rx_link_ctrl
  import epcs_pkg::*;
#(
  parameter logic [EPCS_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int FRAME_LEN = 16,
  parameter int LOCK_CNT  = 8,
  parameter int LOSS_CNT  = 4,
  parameter int HUNT_TMO  = 64,
  parameter int SLIP_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EPCS_W-1:0] rxd,
  input  logic              rxval,
  input  logic              err_clr,
  output logic              slip,
  output logic              link_up,
  output logic [EPCS_W-1:0] dout,
  output logic              dval,
  output logic              sof,
  output logic [15:0]       err_cnt,
  output logic [1:0]        state
);
  // Handshake: rxval qualifies rxd and dval qualifies dout/sof, one word per
  // cycle; there is no backpressure, every valid word is consumed.
  localparam int WP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int TMO_W = (HUNT_TMO > 1) ? $clog2(HUNT_TMO) : 1;
  localparam int SW_W = $clog2(SLIP_WAIT + 1);
  localparam int CW = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HUNT_TMO - 1);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SLIP_WAIT);
  localparam logic [CW-1:0] GOOD_LAST = CW'(LOCK_CNT - 2);
  localparam logic [CW-1:0] MISS_LAST = CW'(LOSS_CNT - 1);

  state_t          st;
  logic [WP_W-1:0] wpos;
  logic [TMO_W-1:0] tmo;
  logic [SW_W-1:0] swait;
  logic [CW-1:0]   good_cnt;
  logic [CW-1:0]   miss_cnt;
  logic            is_sync;
  logic            bnd;
  logic            lock_hit;
  logic            loss_hit;
  logic            bad_locked;

  assign is_sync    = (rxd == SYNC_WORD);
  assign bnd        = rxval && (wpos == '0);
  assign bad_locked = (st == ST_LOCKED) && bnd && !is_sync;
  // good_cnt holds (good syncs - 1): the HUNT match that opened VERIFY is the first.
  assign lock_hit   = (st == ST_VERIFY) && bnd && is_sync && (good_cnt == GOOD_LAST);
  assign loss_hit   = bad_locked && (miss_cnt == MISS_LAST);
  assign state      = st;

  epcs_sync_cnt #(.W(CW)) u_good (
    .clk (clk),
    .rst (rst),
    .clr (st != ST_VERIFY),
    .inc ((st == ST_VERIFY) && bnd && is_sync),
    .cnt (good_cnt)
  );

  epcs_sync_cnt #(.W(CW)) u_miss (
    .clk (clk),
    .rst (rst),
    .clr ((st != ST_LOCKED) || (bnd && is_sync)),
    .inc (bad_locked),
    .cnt (miss_cnt)
  );

  epcs_sync_cnt #(.W(16)) u_err (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (bad_locked),
    .cnt (err_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_HUNT;
      wpos    <= '0;
      tmo     <= '0;
      swait   <= '0;
      slip    <= 1'b0;
      link_up <= 1'b0;
      dout    <= '0;
      dval    <= 1'b0;
      sof     <= 1'b0;
    end else begin
      slip <= 1'b0;
      dval <= rxval && ((st == ST_LOCKED) || lock_hit);
      sof  <= bnd && (st == ST_LOCKED);
      if (rxval) dout <= rxd;
      case (st)
        ST_HUNT: begin
          if (rxval) begin
            if (is_sync) begin
              st   <= ST_VERIFY;
              wpos <= WP_W'(1);
              tmo  <= '0;
            end else if (tmo == TMO_LAST) begin
              st    <= ST_SLIP;
              slip  <= 1'b1;
              tmo   <= '0;
              swait <= '0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
        end
        // One slip cycle followed by SLIP_WAIT settling cycles, rxval ignored.
        ST_SLIP: begin
          if (swait == SW_LAST) st <= ST_HUNT;
          else swait <= swait + 1'b1;
        end
        ST_VERIFY: begin
          if (rxval) begin
            wpos <= wpos + 1'b1;
            if (bnd && !is_sync) begin
              st <= ST_HUNT;
            end else if (lock_hit) begin
              st      <= ST_LOCKED;
              link_up <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (rxval) begin
            wpos <= wpos + 1'b1;
            if (loss_hit) begin
              st      <= ST_HUNT;
              link_up <= 1'b0;
            end
          end
        end
        default: st <= ST_HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_epcs_rx_link_ctrl.sv
// Bench for epcs_rx_link_ctrl: random framed/unframed streams against a
// word-by-word reference model, outputs checked by a decoupled monitor.
module tb_epcs_rx_link_ctrl;
  localparam logic [19:0] SYNC = 20'hCF9C3;
  localparam int FL = 16;
  localparam int LOCK_N = 8;
  localparam int LOSS_N = 4;
  localparam int TMO_N = 64;
  localparam int WAIT_N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] rxd = '0;
  logic        rxval = 1'b0;
  logic        err_clr = 1'b0;
  logic        slip, link_up, dval, sof;
  logic [19:0] dout;
  logic [15:0] err_cnt;
  logic [1:0]  state;
  logic        sc_clr = 1'b1;
  logic        sc_inc = 1'b0;
  logic [3:0]  sc_cnt;

  // exp_q entry: {state[1:0], link_up, slip, dval, sof, err_cnt[15:0]}
  logic [21:0] exp_q[$];
  logic [19:0] dat_q[$];
  int n_vec = 0;
  int n_err = 0;

  int m_st, m_pos, m_tmo, m_wait, m_good, m_miss, m_err;

  epcs_rx_link_ctrl #(
    .SYNC_WORD (SYNC),
    .FRAME_LEN (FL),
    .LOCK_CNT  (LOCK_N),
    .LOSS_CNT  (LOSS_N),
    .HUNT_TMO  (TMO_N),
    .SLIP_WAIT (WAIT_N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rxd     (rxd),
    .rxval   (rxval),
    .err_clr (err_clr),
    .slip    (slip),
    .link_up (link_up),
    .dout    (dout),
    .dval    (dval),
    .sof     (sof),
    .err_cnt (err_cnt),
    .state   (state)
  );

  epcs_sync_cnt #(.W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .clr (sc_clr),
    .inc (sc_inc),
    .cnt (sc_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [19:0] rnd_word();
    logic [19:0] w = 20'($urandom);
    if (w == SYNC) w = ~w;
    return w;
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_st = 0; m_pos = 0; m_tmo = 0; m_wait = 0; m_good = 0; m_miss = 0; m_err = 0;
    dat_q.delete();
    exp_q.push_back(22'd0);
  endtask

  // Advances the model by one clock with the given inputs and queues the
  // outputs the DUT must show after that clock edge.
  task automatic model_step(input logic [19:0] d, input bit v, input bit clr);
    bit sync, bound, e_slip, e_dval, e_sof;
    int nst;
    sync   = (d == SYNC);
    bound  = v && (m_pos == 0);
    e_slip = 1'b0;
    e_sof  = bound && (m_st == 3);
    nst    = m_st;
    case (m_st)
      0: if (v) begin
        if (sync) begin
          nst = 2; m_pos = 1; m_good = 1; m_tmo = 0;
        end else begin
          m_tmo++;
          if (m_tmo == TMO_N) begin
            nst = 1; m_tmo = 0; m_wait = 0; e_slip = 1'b1;
          end
        end
      end
      1: begin
        m_wait++;
        if (m_wait == WAIT_N + 1) nst = 0;
      end
      2: if (v) begin
        if (bound) begin
          if (sync) begin
            m_good++;
            if (m_good == LOCK_N) nst = 3;
          end else begin
            nst = 0; m_good = 0;
          end
        end
        m_pos = (m_pos + 1) % FL;
      end
      default: if (v) begin
        if (bound) begin
          if (sync) m_miss = 0;
          else begin
            m_miss++;
            if (m_err < 65535) m_err++;
            if (m_miss == LOSS_N) begin
              nst = 0; m_miss = 0;
            end
          end
        end
        m_pos = (m_pos + 1) % FL;
      end
    endcase
    if (clr) m_err = 0;
    e_dval = v && (m_st == 3 || nst == 3);
    m_st = nst;
    exp_q.push_back({2'(nst), (nst == 3), e_slip, e_dval, e_sof, 16'(m_err)});
    if (e_dval) dat_q.push_back(d);
  endtask

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic step(input logic [19:0] d, input bit v, input bit c);
    rxd = d; rxval = v; err_clr = c;
    model_step(d, v, c);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rxval = 1'b0; err_clr = 1'b0; rxd = '0;
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic stream_frames(input int n, input bit bad, input bit tog, input bit clr, input bit dup);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < FL; i++) begin
        logic [19:0] w;
        if (i == 0) w = bad ? (SYNC ^ 20'h00100) : SYNC;
        else if (dup && i == 5) w = SYNC;
        else w = rnd_word();
        if (tog) step(($urandom_range(0, 3) == 0) ? SYNC : rnd_word(), 1'b0, 1'b0);
        step(w, 1'b1, clr && (i == 0));
      end
    end
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) step(rnd_word(), 1'b1, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin : mon
    logic [21:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",   32'(state),   32'(e[21:20]));
      chk("link_up", 32'(link_up), 32'(e[19]));
      chk("slip",    32'(slip),    32'(e[18]));
      chk("dval",    32'(dval),    32'(e[17]));
      chk("sof",     32'(sof),     32'(e[16]));
      chk("err_cnt", 32'(err_cnt), 32'(e[15:0]));
    end
    if (dval === 1'b1) begin
      if (dat_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dout at %0t: dval high with no expected word, got %h", $time, dout);
      end else begin
        chk("dout", 32'(dout), 32'(dat_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    @(posedge clk); #1;
    do_reset();
    sc_clr = 1'b0;

    // aligned stream: lock, framed output, stray syncs off-boundary
    stream_frames(10, 1'b0, 1'b0, 1'b0, 1'b0);
    stream_frames(4, 1'b0, 1'b0, 1'b0, 1'b1);
    stream_frames(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3 bad syncs survive, 4 drop the link; relock; clear on an increment cycle
    stream_frames(3, 1'b1, 1'b0, 1'b0, 1'b0);
    stream_frames(2, 1'b0, 1'b0, 1'b0, 1'b0);
    stream_frames(4, 1'b1, 1'b0, 1'b0, 1'b0);
    stream_frames(10, 1'b0, 1'b0, 1'b0, 1'b0);
    stream_frames(1, 1'b1, 1'b0, 1'b1, 1'b0);
    stream_frames(2, 1'b0, 1'b0, 1'b0, 1'b0);

    // unframed data: link loss then periodic slips; reset inside a slip wait
    rand_words(300);
    guard = 0;
    while (!(m_st == 1 && m_wait == 5) && guard < 200) begin
      step(rnd_word(), 1'b1, 1'b0);
      guard++;
    end
    chk("reach_slip_wait", 32'(m_st == 1), 32'd1);
    do_reset();

    // rxval toggling every cycle
    stream_frames(20, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset while locked, then relock
    chk("locked_before_reset", 32'(m_st), 32'd3);
    do_reset();
    stream_frames(12, 1'b0, 1'b0, 1'b0, 1'b0);

    // saturation and clear-over-increment on the counter block
    sc_inc = 1'b1;
    repeat (20) step(20'h0, 1'b0, 1'b0);
    chk("sat_cnt", 32'(sc_cnt), 32'd15);
    sc_clr = 1'b1;
    step(20'h0, 1'b0, 1'b0);
    chk("sat_clr", 32'(sc_cnt), 32'd0);

    repeat (3) step(20'h0, 1'b0, 1'b0);
    #5;
    chk("queues_drained", 32'(exp_q.size() + dat_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
